// File: rtl/rfphoenix_ptg_cache.sv
// Page-table-group cache for the MMU table walker: DEPTH lines of PTES HPTEs, tagged by PTG address.
// HPTE layout: [0] valid, [1] global, [11:2] asid, [27:12] vpn, [127:28] payload.
module rfphoenix_ptg_cache #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTES  = 8,
  parameter int unsigned ADR_W = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     req_v_i,
  output logic                                     req_rdy_o,
  input  logic [ADR_W-1:0]                         req_adr_i,
  input  logic [15:0]                              req_vpn_i,
  input  logic [9:0]                               req_asid_i,
  output logic                                     resp_v_o,
  input  logic                                     resp_rdy_i,
  output logic                                     resp_hit_o,
  output logic                                     resp_tag_o,
  output logic [((PTES > 1) ? $clog2(PTES) : 1)-1:0] resp_idx_o,
  output logic [127:0]                             resp_pte_o,
  input  logic                                     fill_v_i,
  output logic                                     fill_rdy_o,
  input  logic [ADR_W-1:0]                         fill_adr_i,
  input  logic [PTES*128-1:0]                      fill_ptg_i,
  input  logic                                     inv_all_i,
  output logic [31:0]                              hit_cnt_o,
  output logic [31:0]                              miss_cnt_o
);

  localparam int unsigned PTE_W    = 128;
  localparam int unsigned LINE_W   = PTES * PTE_W;
  localparam int unsigned IDX_W    = (PTES > 1) ? $clog2(PTES) : 1;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned V_BIT    = 0;
  localparam int unsigned G_BIT    = 1;
  localparam int unsigned ASID_LSB = 2;
  localparam int unsigned VPN_LSB  = 12;

  typedef enum logic [1:0] {ST_IDLE, ST_TAG, ST_SEL, ST_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [DEPTH-1:0]    r_valid;
  logic [ADR_W-1:0]    r_tags  [DEPTH];
  logic [LINE_W-1:0]   r_lines [DEPTH];
  logic [PTR_W-1:0]    r_vict;
  logic [ADR_W-1:0]    r_adr;
  logic [15:0]         r_vpn;
  logic [9:0]          r_asid;
  logic                r_tag_hit;
  logic [PTR_W-1:0]    r_tag_idx;
  logic                r_resp_v, r_resp_hit, r_resp_tag;
  logic [IDX_W-1:0]    r_resp_idx;
  logic [PTE_W-1:0]    r_resp_pte;
  logic [31:0]         r_hit_cnt, r_miss_cnt;

  logic                w_req_take, w_fill_take;
  logic                w_lk_hit, w_fl_hit;
  logic [PTR_W-1:0]    w_lk_idx, w_fl_idx, w_fill_wr_idx;
  logic [LINE_W-1:0]   w_line;
  logic                w_pte_any, w_sel_tag, w_sel_hit;
  logic [IDX_W-1:0]    w_pte_idx;
  logic [PTE_W-1:0]    w_pte;

  function automatic logic pte_match(input logic [PTE_W-1:0] p, input logic [15:0] vpn,
                                     input logic [9:0] asid);
    return p[V_BIT] && (p[VPN_LSB +: 16] == vpn) && (p[G_BIT] || (p[ASID_LSB +: 10] == asid));
  endfunction

  assign w_req_take    = (r_state == ST_IDLE) && req_v_i && !fill_v_i;
  assign w_fill_take   = (r_state == ST_IDLE) && fill_v_i;
  assign w_fill_wr_idx = w_fl_hit ? w_fl_idx : r_vict;

  // Tag compare for the lookup in flight and for an incoming fill; tags are unique.
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_idx = '0;
    w_fl_hit = 1'b0;
    w_fl_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tags[i] == r_adr)) begin
        w_lk_hit = 1'b1;
        w_lk_idx = PTR_W'(i);
      end
      if (r_valid[i] && (r_tags[i] == fill_adr_i)) begin
        w_fl_hit = 1'b1;
        w_fl_idx = PTR_W'(i);
      end
    end
  end

  // Lowest-index matching HPTE within the tagged line; an invalidate now forces a miss.
  always_comb begin
    w_line    = r_lines[r_tag_idx];
    w_pte_any = 1'b0;
    w_pte_idx = '0;
    w_pte     = '0;
    for (int j = int'(PTES) - 1; j >= 0; j--) begin
      if (pte_match(w_line[j*PTE_W +: PTE_W], r_vpn, r_asid)) begin
        w_pte_any = 1'b1;
        w_pte_idx = IDX_W'(j);
        w_pte     = w_line[j*PTE_W +: PTE_W];
      end
    end
    w_sel_tag = r_tag_hit && !inv_all_i;
    w_sel_hit = w_sel_tag && w_pte_any;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req_take) w_state_nxt = ST_TAG;
      ST_TAG:  w_state_nxt = ST_SEL;
      ST_SEL:  w_state_nxt = ST_RESP;
      ST_RESP: if (resp_rdy_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid    <= '0;
      r_vict     <= '0;
      r_adr      <= '0;
      r_vpn      <= '0;
      r_asid     <= '0;
      r_tag_hit  <= 1'b0;
      r_tag_idx  <= '0;
      r_resp_v   <= 1'b0;
      r_resp_hit <= 1'b0;
      r_resp_tag <= 1'b0;
      r_resp_idx <= '0;
      r_resp_pte <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (inv_all_i) begin
        r_valid <= '0;
        r_vict  <= '0;
      end else if (w_fill_take) begin
        r_valid[w_fill_wr_idx] <= 1'b1;
        if (!w_fl_hit) r_vict <= r_vict + PTR_W'(1);
      end
      if (w_req_take) begin
        r_adr  <= req_adr_i;
        r_vpn  <= req_vpn_i;
        r_asid <= req_asid_i;
      end
      if (r_state == ST_TAG) begin
        r_tag_hit <= w_lk_hit && !inv_all_i;
        r_tag_idx <= w_lk_idx;
      end
      if (r_state == ST_SEL) begin
        r_resp_v   <= 1'b1;
        r_resp_hit <= w_sel_hit;
        r_resp_tag <= w_sel_tag;
        r_resp_idx <= w_sel_hit ? w_pte_idx : '0;
        r_resp_pte <= w_sel_hit ? w_pte : '0;
        if (w_sel_hit) begin
          if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
        end else begin
          if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
      end
      if ((r_state == ST_RESP) && resp_rdy_i) r_resp_v <= 1'b0;
    end
  end

  // Line storage carries no reset; the valid bits gate it.
  always_ff @(posedge clk_i) begin
    if (w_fill_take && !inv_all_i) begin
      r_tags[w_fill_wr_idx]  <= fill_adr_i;
      r_lines[w_fill_wr_idx] <= fill_ptg_i;
    end
  end

  assign req_rdy_o  = (r_state == ST_IDLE) && !fill_v_i;
  assign fill_rdy_o = (r_state == ST_IDLE);
  assign resp_v_o   = r_resp_v;
  assign resp_hit_o = r_resp_hit;
  assign resp_tag_o = r_resp_tag;
  assign resp_idx_o = r_resp_idx;
  assign resp_pte_o = r_resp_pte;
  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;

endmodule

// File: tb/tb_rfphoenix_ptg_cache.sv
// Directed bench for rfphoenix_ptg_cache at default parameters (DEPTH=8, PTES=8, ADR_W=32).
module tb_rfphoenix_ptg_cache;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_v, req_rdy, resp_v, resp_rdy, resp_hit, resp_tag;
  logic [31:0]    req_adr, fill_adr, hit_cnt, miss_cnt;
  logic [15:0]    req_vpn;
  logic [9:0]     req_asid;
  logic [2:0]     resp_idx;
  logic [127:0]   resp_pte;
  logic           fill_v, fill_rdy, inv_all;
  logic [1023:0]  fill_ptg, line;

  int n_vec = 0;
  int n_err = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  rfphoenix_ptg_cache dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_v_i(req_v), .req_rdy_o(req_rdy), .req_adr_i(req_adr), .req_vpn_i(req_vpn),
    .req_asid_i(req_asid), .resp_v_o(resp_v), .resp_rdy_i(resp_rdy), .resp_hit_o(resp_hit),
    .resp_tag_o(resp_tag), .resp_idx_o(resp_idx), .resp_pte_o(resp_pte),
    .fill_v_i(fill_v), .fill_rdy_o(fill_rdy), .fill_adr_i(fill_adr), .fill_ptg_i(fill_ptg),
    .inv_all_i(inv_all), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_pte(input logic v, input logic g, input logic [15:0] vpn,
                                          input logic [9:0] asid, input logic [99:0] pay);
    return {pay, vpn, asid, g, v};
  endfunction

  task automatic fill(input logic [31:0] adr, input logic [1023:0] ptg, input logic inv);
    @(negedge clk);
    fill_v = 1'b1; fill_adr = adr; fill_ptg = ptg; inv_all = inv;
    #1 chk("fill_rdy", fill_rdy, 1);
    @(negedge clk);
    fill_v = 1'b0; inv_all = 1'b0;
  endtask

  // Called after the acceptance edge; optionally pulses inv_all during TAG and stalls resp_rdy.
  task automatic await_resp(input logic eh, input logic et, input logic [2:0] ei,
                            input logic [127:0] ep, input int hold, input logic inv);
    int cyc = 0;
    if (eh) exp_hit++; else exp_miss++;
    do begin
      @(negedge clk);
      cyc++;
      req_v = 1'b0;
      inv_all = (cyc == 1) ? inv : 1'b0;
    end while (!resp_v && cyc < 20);
    chk("latency", 128'(cyc), 3);
    chk("hit", resp_hit, eh);
    chk("tag", resp_tag, et);
    chk("pte", resp_pte, ep);
    if (eh) chk("idx", resp_idx, ei);
    chk("hit_cnt", hit_cnt, 128'(exp_hit));
    chk("miss_cnt", miss_cnt, 128'(exp_miss));
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("hold_v", resp_v, 1);
      chk("hold_hit", resp_hit, eh);
      chk("hold_tag", resp_tag, et);
      chk("hold_pte", resp_pte, ep);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    chk("resp_drop", resp_v, 0);
  endtask

  task automatic lookup(input logic [31:0] adr, input logic [15:0] vpn, input logic [9:0] asid,
                        input logic eh, input logic et, input logic [2:0] ei,
                        input logic [127:0] ep, input int hold, input logic inv);
    @(negedge clk);
    req_v = 1'b1; req_adr = adr; req_vpn = vpn; req_asid = asid;
    #1 chk("req_rdy", req_rdy, 1);
    @(posedge clk);
    await_resp(eh, et, ei, ep, hold, inv);
  endtask

  initial begin
    logic [127:0] p3, p3g;
    rst_n = 1'b0; req_v = 1'b0; resp_rdy = 1'b0; fill_v = 1'b0; inv_all = 1'b0;
    req_adr = '0; req_vpn = '0; req_asid = '0; fill_adr = '0; fill_ptg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_v", resp_v, 0);
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_fill_rdy", fill_rdy, 1);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_pte", resp_pte, 0);
    rst_n = 1'b1;

    // Cold miss
    lookup(32'h1000, 16'h12, 10'd5, 0, 0, 0, 0, 0, 0);

    // Line with an invalid, an asid-mismatch and two true matches (3 and 5)
    p3 = mk_pte(1, 0, 16'h12, 10'd5, 100'h3);
    line = '0;
    line[1*128 +: 128] = mk_pte(0, 0, 16'h12, 10'd5, 100'h1);
    line[2*128 +: 128] = mk_pte(1, 0, 16'h12, 10'd7, 100'h2);
    line[3*128 +: 128] = p3;
    line[5*128 +: 128] = mk_pte(1, 0, 16'h12, 10'd5, 100'h5);
    fill(32'h1000, line, 0);
    lookup(32'h1000, 16'h12, 10'd5, 1, 1, 3, p3, 0, 0);
    lookup(32'h1000, 16'h12, 10'd6, 0, 1, 0, 0, 0, 0);

    // In-place refill with HPTE 3 global
    p3g = mk_pte(1, 1, 16'h12, 10'd5, 100'h3);
    line[3*128 +: 128] = p3g;
    fill(32'h1000, line, 0);
    lookup(32'h1000, 16'h12, 10'd6, 1, 1, 3, p3g, 0, 0);

    // Seven new lines fill entries 1..7 only if the refill left the pointer alone
    for (int k = 1; k <= 7; k++) fill(32'h2000 + 32'(k) * 32'h100, '0, 0);
    lookup(32'h1000, 16'h12, 10'd5, 1, 1, 3, p3g, 0, 0);

    @(negedge clk); inv_all = 1'b1;
    @(negedge clk); inv_all = 1'b0;
    lookup(32'h1000, 16'h12, 10'd5, 0, 0, 0, 0, 0, 0);

    // DEPTH+1 distinct fills: first evicted, pointer left at 1
    for (int k = 1; k <= 9; k++) begin
      line = '0;
      line[127:0] = mk_pte(1, 0, 16'h12, 10'd5, 100'(k));
      fill(32'h3000 + 32'(k) * 32'h100, line, 0);
    end
    lookup(32'h3100, 16'h12, 10'd5, 0, 0, 0, 0, 0, 0);
    for (int k = 2; k <= 9; k++)
      lookup(32'h3000 + 32'(k) * 32'h100, 16'h12, 10'd5, 1, 1, 0,
             mk_pte(1, 0, 16'h12, 10'd5, 100'(k)), 0, 0);
    fill(32'h3A00, '0, 0);
    lookup(32'h3200, 16'h12, 10'd5, 0, 0, 0, 0, 0, 0);
    lookup(32'h3300, 16'h12, 10'd5, 1, 1, 0, mk_pte(1, 0, 16'h12, 10'd5, 100'h3), 0, 0);

    // Fill and request together: fill wins, request taken next cycle and hits
    line = '0;
    line[7*128 +: 128] = mk_pte(1, 0, 16'h12, 10'd5, 100'h77);
    @(negedge clk);
    fill_v = 1'b1; fill_adr = 32'h5000; fill_ptg = line;
    req_v = 1'b1; req_adr = 32'h5000; req_vpn = 16'h12; req_asid = 10'd5;
    #1 chk("both_req_rdy", req_rdy, 0);
    chk("both_fill_rdy", fill_rdy, 1);
    @(negedge clk);
    fill_v = 1'b0;
    #1 chk("next_req_rdy", req_rdy, 1);
    @(posedge clk);
    await_resp(1, 1, 7, mk_pte(1, 0, 16'h12, 10'd5, 100'h77), 0, 0);

    // Invalidate during TAG of a would-be hit, then a stalled response
    lookup(32'h5000, 16'h12, 10'd5, 0, 0, 0, 0, 5, 1);

    // Invalidate alongside a fill: line stays invalid
    fill(32'h6000, line, 1);
    lookup(32'h6000, 16'h12, 10'd5, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
